// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter that rasterises one BOX_W x BOX_H box per grant into a VGA pixel port.
// Optional macro DRAW_ARB_RESET_PRIORITY_EN gives requester 0 absolute priority.
module vga_draw_arbiter #(
  parameter int BOX_W = 4,
  parameter int BOX_H = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [23:0] req_x,
  input  logic [20:0] req_y,
  input  logic [8:0]  req_colour,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic        busy,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot
);

  typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} state_t;

  localparam logic [3:0] CX_LAST = 4'(BOX_W - 1);
  localparam logic [3:0] CY_LAST = 4'(BOX_H - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_last;
  logic [1:0] r_winner;
  logic [1:0] w_pick;
  logic [7:0] r_ox;
  logic [6:0] r_oy;
  logic [2:0] r_col;
  logic [3:0] r_cx;
  logic [3:0] r_cy;
  logic       w_row_end;
  logic       w_box_end;
  logic [7:0] w_sel_x;
  logic [6:0] w_sel_y;
  logic [2:0] w_sel_c;

`ifdef DRAW_ARB_RESET_PRIORITY_EN
  // Board reset always wins; the two players alternate among themselves.
  function automatic logic [1:0] pick_winner(input logic [2:0] r, input logic [1:0] last);
    if (r[0]) return 2'd0;
    if (r[1] && r[2]) return (last == 2'd1) ? 2'd2 : 2'd1;
    return r[1] ? 2'd1 : 2'd2;
  endfunction
`else
  function automatic logic [1:0] pick_winner(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      int k;
      k = (int'(last) + i) % 3;
      if (!found && r[k]) begin
        pick  = 2'(k);
        found = 1'b1;
      end
    end
    return pick;
  endfunction
`endif

  assign w_pick    = pick_winner(req, r_last);
  assign w_row_end = (r_cx == CX_LAST);
  assign w_box_end = w_row_end && (r_cy == CY_LAST);

  always_comb begin
    w_sel_x = req_x[7:0];
    w_sel_y = req_y[6:0];
    w_sel_c = req_colour[2:0];
    case (r_winner)
      2'd1: begin
        w_sel_x = req_x[15:8];
        w_sel_y = req_y[13:7];
        w_sel_c = req_colour[5:3];
      end
      2'd2: begin
        w_sel_x = req_x[23:16];
        w_sel_y = req_y[20:14];
        w_sel_c = req_colour[8:6];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req) w_state_nxt = LATCH;
      LATCH:   w_state_nxt = DRAW;
      DRAW:    if (w_box_end) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pixel outputs are registered so that x/y always equal origin + (cx, cy) while plot is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant    <= 3'b000;
      done     <= 3'b000;
      busy     <= 1'b0;
      plot     <= 1'b0;
      x        <= 8'd0;
      y        <= 7'd0;
      colour   <= 3'd0;
      r_cx     <= 4'd0;
      r_cy     <= 4'd0;
      r_last   <= 2'd2;
      r_winner <= 2'd0;
      r_ox     <= 8'd0;
      r_oy     <= 7'd0;
      r_col    <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_winner <= w_pick;
            grant    <= 3'b001 << w_pick;
            busy     <= 1'b1;
          end
        end
        LATCH: begin
          r_ox   <= w_sel_x;
          r_oy   <= w_sel_y;
          r_col  <= w_sel_c;
          r_cx   <= 4'd0;
          r_cy   <= 4'd0;
          x      <= w_sel_x;
          y      <= w_sel_y;
          colour <= w_sel_c;
          plot   <= 1'b1;
        end
        DRAW: begin
          if (w_box_end) begin
            plot <= 1'b0;
            done <= 3'b001 << r_winner;
          end else if (w_row_end) begin
            r_cx <= 4'd0;
            r_cy <= r_cy + 4'd1;
            x    <= r_ox;
            y    <= r_oy + {3'b000, r_cy} + 7'd1;
          end else begin
            r_cx <= r_cx + 4'd1;
            x    <= r_ox + {4'b0000, r_cx} + 8'd1;
          end
        end
        DONE: begin
          done   <= 3'b000;
          grant  <= 3'b000;
          busy   <= 1'b0;
          r_last <= r_winner;
        end
        default: ;
      endcase
    end
  end

endmodule
